// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared widths, writeback-select enum and branch funct3 codes
package riscv_pkg;

  localparam int XLEN   = 64;
  localparam int REG_AW = 5;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10
  } result_src_e;

  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;

endpackage

// File: rtl/branch_resolve.sv
// rtl/branch_resolve.sv - combinational branch condition, redirect target and misalignment detect
import riscv_pkg::*;

module branch_resolve (
  input  logic            valid,
  input  logic            branch,
  input  logic            jump,
  input  logic            jalr,
  input  logic            zero,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:1] alu_hi,
  output logic [XLEN-1:0] target,
  output logic            take,
  output logic            mis
);

  logic cond;

  // Branch condition from funct3; unsupported compares simply fall through as not taken
  always_comb begin
    cond = 1'b0;
    case (funct3)
      F3_BEQ:  cond = zero;
      F3_BNE:  cond = !zero;
      default: cond = 1'b0;
    endcase
  end

  // JALR clears bit 0 of the ALU sum; everything else is PC-relative and wraps naturally
  always_comb begin
    target = jalr ? {alu_hi, 1'b0} : pc + imm;
    take   = valid & (jump | (branch & cond));
    mis    = take & (target[1:0] != 2'b00);
  end

endmodule

// File: rtl/ex_mem_stage.sv
// rtl/ex_mem_stage.sv - EX back end and EX/MEM register; EX_PERF_CNT_EN enables branch perf counters
import riscv_pkg::*;

module ex_mem_stage (
  input  logic              clk,
  input  logic              rst,
  input  logic              StallM,
  input  logic              ValidE,
  input  logic [XLEN-1:0]   ALUResultE,
  input  logic              ZeroE,
  input  logic [XLEN-1:0]   PCE,
  input  logic [XLEN-1:0]   ImmExtE,
  input  logic [XLEN-1:0]   PCPlus4E,
  input  logic [XLEN-1:0]   WriteDataE,
  input  logic [REG_AW-1:0] RdE,
  input  logic              RegWriteE,
  input  logic              MemWriteE,
  input  logic              BranchE,
  input  logic              JumpE,
  input  logic              JalrE,
  input  logic [1:0]        ResultSrcE,
  input  logic [2:0]        Funct3E,
  output logic              PCSrcE,
  output logic [XLEN-1:0]   PCTargetE,
  output logic              ValidM,
  output logic              RegWriteM,
  output logic              MemWriteM,
  output logic              TrapM,
  output logic [XLEN-1:0]   ALUResultM,
  output logic [XLEN-1:0]   WriteDataM,
  output logic [XLEN-1:0]   PCPlus4M,
  output logic [REG_AW-1:0] RdM,
  output logic [1:0]        ResultSrcM,
  output logic [63:0]       BrTotalCnt,
  output logic [63:0]       BrTakenCnt
);

  logic take, mis, advance;

  logic              valid_q, valid_d;
  logic              reg_write_q, reg_write_d;
  logic              mem_write_q, mem_write_d;
  logic              trap_q, trap_d;
  logic [XLEN-1:0]   alu_result_q, alu_result_d;
  logic [XLEN-1:0]   write_data_q, write_data_d;
  logic [XLEN-1:0]   pc_plus4_q, pc_plus4_d;
  logic [REG_AW-1:0] rd_q, rd_d;
  result_src_e       result_src_q, result_src_d;

  branch_resolve u_branch_resolve (
    .valid  (ValidE),
    .branch (BranchE),
    .jump   (JumpE),
    .jalr   (JalrE),
    .zero   (ZeroE),
    .funct3 (Funct3E),
    .pc     (PCE),
    .imm    (ImmExtE),
    .alu_hi (ALUResultE[XLEN-1:1]),
    .target (PCTargetE),
    .take   (take),
    .mis    (mis)
  );

  // Redirect only in the advancing cycle so a stalled instruction redirects exactly once
  always_comb begin
    advance = !rst & !StallM;
    PCSrcE  = advance & take & !mis;
  end

  // Next EX/MEM contents: hold on stall, otherwise capture with misaligned jumps squashing writeback
  always_comb begin
    valid_d      = valid_q;
    reg_write_d  = reg_write_q;
    mem_write_d  = mem_write_q;
    trap_d       = trap_q;
    alu_result_d = alu_result_q;
    write_data_d = write_data_q;
    pc_plus4_d   = pc_plus4_q;
    rd_d         = rd_q;
    result_src_d = result_src_q;
    if (!StallM) begin
      valid_d      = ValidE;
      reg_write_d  = ValidE & RegWriteE & !mis;
      mem_write_d  = ValidE & MemWriteE;
      trap_d       = mis;
      alu_result_d = ALUResultE;
      write_data_d = WriteDataE;
      pc_plus4_d   = PCPlus4E;
      rd_d         = RdE;
      result_src_d = result_src_e'(ResultSrcE);
    end
  end

  // EX/MEM register; reset takes priority over stall
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q      <= 1'b0;
      reg_write_q  <= 1'b0;
      mem_write_q  <= 1'b0;
      trap_q       <= 1'b0;
      alu_result_q <= '0;
      write_data_q <= '0;
      pc_plus4_q   <= '0;
      rd_q         <= '0;
      result_src_q <= RES_ALU;
    end else begin
      valid_q      <= valid_d;
      reg_write_q  <= reg_write_d;
      mem_write_q  <= mem_write_d;
      trap_q       <= trap_d;
      alu_result_q <= alu_result_d;
      write_data_q <= write_data_d;
      pc_plus4_q   <= pc_plus4_d;
      rd_q         <= rd_d;
      result_src_q <= result_src_d;
    end
  end

  assign ValidM     = valid_q;
  assign RegWriteM  = reg_write_q;
  assign MemWriteM  = mem_write_q;
  assign TrapM      = trap_q;
  assign ALUResultM = alu_result_q;
  assign WriteDataM = write_data_q;
  assign PCPlus4M   = pc_plus4_q;
  assign RdM        = rd_q;
  assign ResultSrcM = result_src_q;

`ifdef EX_PERF_CNT_EN
  logic [63:0] br_total_q, br_total_d;
  logic [63:0] br_taken_q, br_taken_d;

  // Count advancing control-flow instructions and the redirects they produce
  always_comb begin
    br_total_d = br_total_q;
    br_taken_d = br_taken_q;
    if (advance & ValidE & (BranchE | JumpE)) br_total_d = br_total_q + 64'd1;
    if (PCSrcE) br_taken_d = br_taken_q + 64'd1;
  end

  // Perf counter state
  always_ff @(posedge clk) begin
    if (rst) begin
      br_total_q <= '0;
      br_taken_q <= '0;
    end else begin
      br_total_q <= br_total_d;
      br_taken_q <= br_taken_d;
    end
  end

  assign BrTotalCnt = br_total_q;
  assign BrTakenCnt = br_taken_q;
`else
  assign BrTotalCnt = 64'd0;
  assign BrTakenCnt = 64'd0;
`endif

endmodule

// File: tb/tb_ex_mem_stage.sv
// tb/tb_ex_mem_stage.sv - scoreboard bench for ex_mem_stage with directed vectors
module tb_ex_mem_stage;

  logic        clk = 1'b0;
  logic        rst, StallM, ValidE, ZeroE;
  logic [63:0] ALUResultE, PCE, ImmExtE, PCPlus4E, WriteDataE;
  logic [4:0]  RdE;
  logic        RegWriteE, MemWriteE, BranchE, JumpE, JalrE;
  logic [1:0]  ResultSrcE;
  logic [2:0]  Funct3E;
  logic        PCSrcE, ValidM, RegWriteM, MemWriteM, TrapM;
  logic [63:0] PCTargetE, ALUResultM, WriteDataM, PCPlus4M, BrTotalCnt, BrTakenCnt;
  logic [4:0]  RdM;
  logic [1:0]  ResultSrcM;

  ex_mem_stage dut (
    .clk(clk), .rst(rst), .StallM(StallM), .ValidE(ValidE), .ALUResultE(ALUResultE),
    .ZeroE(ZeroE), .PCE(PCE), .ImmExtE(ImmExtE), .PCPlus4E(PCPlus4E), .WriteDataE(WriteDataE),
    .RdE(RdE), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .BranchE(BranchE), .JumpE(JumpE),
    .JalrE(JalrE), .ResultSrcE(ResultSrcE), .Funct3E(Funct3E), .PCSrcE(PCSrcE),
    .PCTargetE(PCTargetE), .ValidM(ValidM), .RegWriteM(RegWriteM), .MemWriteM(MemWriteM),
    .TrapM(TrapM), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M),
    .RdM(RdM), .ResultSrcM(ResultSrcM), .BrTotalCnt(BrTotalCnt), .BrTakenCnt(BrTakenCnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          tag;
    int          kind;   // 0 comb, 1 M stage, 2 counters
    bit          chk_t;
    logic        pcsrc;
    logic [63:0] target;
    logic        v, rw, mw, tr;
    logic [63:0] alu, wd, pc4;
    logic [4:0]  rd;
    logic [1:0]  rs;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_assert = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_assert++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, expv);
    end
  endtask

  // Monitor: pop every expectation due this cycle and compare against the DUT
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].tag <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      if (e.tag < cyc) chk("late_entry", 64'(e.tag), 64'(cyc));
      case (e.kind)
        0: begin
          chk("PCSrcE", 64'(PCSrcE), 64'(e.pcsrc));
          if (e.chk_t) chk("PCTargetE", PCTargetE, e.target);
        end
        1: begin
          chk("ValidM", 64'(ValidM), 64'(e.v));
          chk("RegWriteM", 64'(RegWriteM), 64'(e.rw));
          chk("MemWriteM", 64'(MemWriteM), 64'(e.mw));
          chk("TrapM", 64'(TrapM), 64'(e.tr));
          chk("ALUResultM", ALUResultM, e.alu);
          chk("WriteDataM", WriteDataM, e.wd);
          chk("PCPlus4M", PCPlus4M, e.pc4);
          chk("RdM", 64'(RdM), 64'(e.rd));
          chk("ResultSrcM", 64'(ResultSrcM), 64'(e.rs));
        end
        default: begin
          chk("BrTotalCnt", BrTotalCnt, e.alu);
          chk("BrTakenCnt", BrTakenCnt, e.wd);
        end
      endcase
    end
  end

  task automatic exp_c(input logic p, input logic [63:0] t, input bit ct);
    exp_t e;
    e = '{default: '0};
    e.tag = cyc; e.kind = 0; e.pcsrc = p; e.target = t; e.chk_t = ct;
    sb.push_back(e);
  endtask

  task automatic exp_m(input logic v, input logic rw, input logic mw, input logic tr,
                       input logic [63:0] alu, input logic [63:0] wd, input logic [63:0] pc4,
                       input logic [4:0] rd, input logic [1:0] rs);
    exp_t e;
    e = '{default: '0};
    e.tag = cyc + 1; e.kind = 1;
    e.v = v; e.rw = rw; e.mw = mw; e.tr = tr;
    e.alu = alu; e.wd = wd; e.pc4 = pc4; e.rd = rd; e.rs = rs;
    sb.push_back(e);
  endtask

  task automatic exp_k(input logic [63:0] total, input logic [63:0] taken);
    exp_t e;
    e = '{default: '0};
    e.tag = cyc; e.kind = 2; e.alu = total; e.wd = taken;
    sb.push_back(e);
  endtask

  task automatic set_ctl(input logic v, input logic br, input logic j, input logic jr,
                         input logic z, input logic [2:0] f3, input logic rw, input logic mw);
    ValidE = v; BranchE = br; JumpE = j; JalrE = jr; ZeroE = z; Funct3E = f3;
    RegWriteE = rw; MemWriteE = mw;
  endtask

  task automatic set_dat(input logic [63:0] pc, input logic [63:0] imm, input logic [63:0] alu,
                         input logic [63:0] wd, input logic [63:0] pc4, input logic [4:0] rd,
                         input logic [1:0] rs);
    PCE = pc; ImmExtE = imm; ALUResultE = alu; WriteDataE = wd; PCPlus4E = pc4;
    RdE = rd; ResultSrcE = rs;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; StallM = 1'b0;
    set_ctl(0, 0, 0, 0, 0, 3'b000, 0, 0);
    set_dat('0, '0, '0, '0, '0, '0, 2'b00);
    repeat (2) @(posedge clk);
    #1;

    // Reset in force: valid JAL must not redirect, M stays cleared
    set_ctl(1, 0, 1, 0, 0, 3'b000, 1, 0);
    set_dat(64'h100, 64'h10, 64'h0, 64'h0, 64'h104, 5'd1, 2'b10);
    exp_c(0, 64'h110, 1); exp_m(0, 0, 0, 0, 0, 0, 0, 0, 0); tick();
    rst = 1'b0;

    // BEQ taken
    set_ctl(1, 1, 0, 0, 1, 3'b000, 0, 0);
    set_dat(64'h1000, 64'h20, 64'h0, 64'hAA, 64'h1004, 5'd0, 2'b00);
    exp_c(1, 64'h1020, 1); exp_m(1, 0, 0, 0, 64'h0, 64'hAA, 64'h1004, 0, 0); tick();

    // BNE with Zero=1: not taken
    set_ctl(1, 1, 0, 0, 1, 3'b001, 0, 0);
    set_dat(64'h2000, 64'h40, 64'h0, 64'hAA, 64'h2004, 5'd0, 2'b00);
    exp_c(0, 64'h2040, 1); exp_m(1, 0, 0, 0, 64'h0, 64'hAA, 64'h2004, 0, 0); tick();

    // Unsupported funct3: never taken, no trap
    set_ctl(1, 1, 0, 0, 0, 3'b100, 0, 0);
    set_dat(64'h3000, 64'h8, 64'h0, 64'hAA, 64'h3004, 5'd0, 2'b00);
    exp_c(0, 64'h3008, 1); exp_m(1, 0, 0, 0, 64'h0, 64'hAA, 64'h3004, 0, 0); tick();

    // Taken BEQ to a halfword-aligned target: trap, RegWrite squashed
    set_ctl(1, 1, 0, 0, 1, 3'b000, 1, 0);
    set_dat(64'h1000, 64'h22, 64'h0, 64'hAA, 64'h1004, 5'd3, 2'b00);
    exp_c(0, 64'h1022, 1); exp_m(1, 0, 0, 1, 64'h0, 64'hAA, 64'h1004, 3, 0); tick();

    // JALR misaligned after bit-0 clear
    set_ctl(1, 0, 1, 1, 0, 3'b000, 1, 0);
    set_dat(64'h4000, 64'h0, 64'h2003, 64'hAA, 64'h4004, 5'd5, 2'b10);
    exp_c(0, 64'h2002, 1); exp_m(1, 0, 0, 1, 64'h2003, 64'hAA, 64'h4004, 5, 2); tick();

    // JAL held three cycles: no redirect, M frozen at the JALR contents
    set_ctl(1, 0, 1, 0, 0, 3'b000, 1, 0);
    set_dat(64'h5000, 64'h100, 64'h77, 64'hAA, 64'h5004, 5'd7, 2'b10);
    StallM = 1'b1;
    for (int i = 0; i < 3; i++) begin
      exp_c(0, 64'h5100, 1); exp_m(1, 0, 0, 1, 64'h2003, 64'hAA, 64'h4004, 5, 2); tick();
    end
    StallM = 1'b0;
    exp_c(1, 64'h5100, 1); exp_m(1, 1, 0, 0, 64'h77, 64'hAA, 64'h5004, 7, 2); tick();

    // Bubble: data captured, controls cleared
    ValidE = 1'b0;
    exp_c(0, 64'h5100, 1); exp_m(0, 0, 0, 0, 64'h77, 64'hAA, 64'h5004, 7, 2); tick();

    // Target wraps modulo 2^64
    set_ctl(1, 1, 0, 0, 1, 3'b000, 0, 0);
    set_dat(64'hFFFF_FFFF_FFFF_FFF0, 64'h20, 64'h0, 64'hAA, 64'hFFFF_FFFF_FFFF_FFF4, 5'd0, 2'b00);
    exp_c(1, 64'h10, 1); exp_m(1, 0, 0, 0, 64'h0, 64'hAA, 64'hFFFF_FFFF_FFFF_FFF4, 0, 0); tick();

    // Store, then reset together with stall: reset wins
    set_ctl(1, 0, 0, 0, 0, 3'b000, 0, 1);
    set_dat(64'h6000, 64'h0, 64'h800, 64'h1234, 64'h6004, 5'd0, 2'b01);
    exp_c(0, 64'h6000, 1); exp_m(1, 0, 1, 0, 64'h800, 64'h1234, 64'h6004, 0, 1); tick();
    rst = 1'b1; StallM = 1'b1;
    set_ctl(1, 0, 1, 0, 0, 3'b000, 1, 0);
    set_dat(64'h7000, 64'h4, 64'h0, 64'h0, 64'h7004, 5'd9, 2'b10);
    exp_c(0, 64'h0, 0); exp_m(0, 0, 0, 0, 0, 0, 0, 0, 0); tick();
    rst = 1'b0; StallM = 1'b0;
    set_ctl(0, 0, 0, 0, 0, 3'b000, 0, 0);
    set_dat('0, '0, '0, '0, '0, '0, 2'b00);
    exp_c(0, 64'h0, 1); exp_m(0, 0, 0, 0, 0, 0, 0, 0, 0); tick();

    // Counter run: 4 branches/jumps, 2 taken, one stalled 2 cycles
    set_dat(64'h100, 64'h8, 64'h0, 64'h0, 64'h104, 5'd1, 2'b00);
    set_ctl(1, 1, 0, 0, 1, 3'b000, 0, 0); exp_c(1, 64'h108, 1); tick();
    set_ctl(1, 1, 0, 0, 1, 3'b001, 0, 0); exp_c(0, 64'h108, 1); tick();
    set_ctl(1, 1, 0, 0, 0, 3'b000, 0, 0); StallM = 1'b1;
    exp_c(0, 64'h108, 1); tick();
    exp_c(0, 64'h108, 1); tick();
    StallM = 1'b0; exp_c(0, 64'h108, 1); tick();
    set_ctl(1, 0, 1, 0, 0, 3'b000, 1, 0); exp_c(1, 64'h108, 1); tick();
    set_ctl(0, 0, 0, 0, 0, 3'b000, 0, 0);
`ifdef EX_PERF_CNT_EN
    exp_k(64'd4, 64'd2);
`else
    exp_k(64'd0, 64'd0);
`endif
    tick();

    repeat (2) tick();
    if (sb.size() != 0) chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
